// File: rtl/gps_bb_quantizer_pkg.sv
// Shared types and width helpers for the GPS baseband combiner/quantiser.
package gps_bb_quantizer_pkg;

    typedef enum logic {
        QM_TWOS    = 1'b0,
        QM_SIGNMAG = 1'b1
    } quant_mode_e;

    typedef struct packed {
        logic [15:0] gain;
        logic [4:0]  shift;
        quant_mode_e mode;
    } quant_cfg_t;

    // Per-sample sideband travelling alongside the data pipeline.
    typedef struct packed {
        logic       valid;
        logic       last;
        quant_cfg_t cfg;
    } quant_tag_t;

    function automatic int unsigned calc_ws(input int unsigned w_in, input int unsigned nch);
        return w_in + $clog2(nch);
    endfunction

    function automatic int unsigned calc_wt(input int unsigned ws);
        return ((ws > 17) ? ws : 17) + 1;
    endfunction

endpackage

// File: rtl/gps_bb_quantizer_slice.sv
// One rail: round/shift stage, then clamp/encode stage with a combinational clip flag
// for the sample currently held in the round/shift register.
module gps_bb_quantizer_slice
    import gps_bb_quantizer_pkg::*;
#(
    parameter int unsigned WT    = 19,
    parameter int unsigned W_OUT = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic signed [WT-1:0] i_v,
    input  logic [4:0]           i_shift,
    input  quant_mode_e          i_mode,
    input  logic                 i_ld,
    output logic [W_OUT-1:0]     o_q,
    output logic                 o_clip
);

    localparam logic signed [WT:0] C_MAX = (WT+1)'(2**(W_OUT-1) - 1);
    localparam logic signed [WT:0] C_MIN = ~C_MAX;

    logic [4:0]           w_s;
    logic signed [WT:0]   w_half;
    logic signed [WT:0]   w_sum;
    logic signed [WT:0]   w_r;
    logic signed [WT:0]   w_m;
    logic                 w_sign;
    logic [W_OUT-1:0]     w_q;
    logic                 w_clip;

    logic signed [WT:0]   r_r;
    quant_mode_e          r_mode;
    logic [W_OUT-1:0]     r_q;

    // One extra bit of headroom so the rounding offset cannot wrap.
    always_comb begin
        w_s    = (32'(i_shift) > WT - 1) ? 5'(WT - 1) : i_shift;
        w_half = '0;
        if (i_mode == QM_TWOS && w_s != 5'd0) begin
            w_half = (WT+1)'(1) << (w_s - 5'd1);
        end
        w_sum = (WT+1)'(i_v) + w_half;
        w_r   = w_sum >>> w_s;
    end

    always_comb begin
        w_clip = 1'b0;
        w_q    = r_r[W_OUT-1:0];
        w_sign = r_r[WT];
        w_m    = w_sign ? ~r_r : r_r;
        if (r_mode == QM_TWOS) begin
            if (r_r > C_MAX) begin
                w_q    = C_MAX[W_OUT-1:0];
                w_clip = 1'b1;
            end else if (r_r < C_MIN) begin
                w_q    = C_MIN[W_OUT-1:0];
                w_clip = 1'b1;
            end
        end else begin
            w_clip = (w_m > C_MAX);
            w_q    = {w_sign, w_clip ? C_MAX[W_OUT-2:0] : w_m[W_OUT-2:0]};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_r    <= '0;
            r_mode <= QM_TWOS;
            r_q    <= '0;
        end else begin
            r_r    <= w_r;
            r_mode <= i_mode;
            if (i_ld) begin
                r_q <= w_q;
            end
        end
    end

    assign o_q    = r_q;
    assign o_clip = w_clip;

endmodule

// File: rtl/gps_bb_quantizer.sv
// Baseband combiner: pipelined channel adder tree, scaled noise add, per-rail quantiser,
// window-aligned config switching and per-window clip statistics.
module gps_bb_quantizer
    import gps_bb_quantizer_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned W_IN     = 16,
    parameter int unsigned W_OUT    = 3,
    parameter int unsigned WIN_LOG2 = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      in_valid,
    input  logic [NCH-1:0][W_IN-1:0]  ch_real,
    input  logic [NCH-1:0][W_IN-1:0]  ch_imag,
    input  logic [15:0]               noise_real,
    input  logic [15:0]               noise_imag,
    input  logic [15:0]               noise_gain,
    input  logic [4:0]                shift,
    input  logic                      mode,
    input  logic                      cfg_load,
    output logic                      cfg_pending,
    output logic                      out_valid,
    output logic [W_OUT-1:0]          real_out,
    output logic [W_OUT-1:0]          imag_out,
    output logic [WIN_LOG2:0]         sat_count,
    output logic                      sat_count_valid
);

    localparam int unsigned WS = calc_ws(W_IN, NCH);
    localparam int unsigned WT = calc_wt(WS);
    localparam int unsigned LV = $clog2(NCH);
    localparam int unsigned NP = 2**LV;

    logic                   w_acc;
    logic                   w_k0;
    quant_cfg_t             w_cfg_port;
    quant_cfg_t             w_cfg_smp;
    logic signed [16:0]     w_gain_s;
    logic signed [16:0]     w_nz_prod_re;
    logic signed [16:0]     w_nz_prod_im;
    logic signed [16:0]     w_nz_re;
    logic signed [16:0]     w_nz_im;
    logic                   w_clip_re;
    logic                   w_clip_im;
    logic                   w_ld;
    logic [WIN_LOG2:0]      w_cnt;

    logic [WIN_LOG2-1:0]    r_k;
    quant_cfg_t             r_active;
    quant_cfg_t             r_pending;
    logic                   r_pend;
    logic signed [15:0]     r_noise_re;
    logic signed [15:0]     r_noise_im;
    logic signed [WT-1:0]   r_node_re [1:2*NP-1];
    logic signed [WT-1:0]   r_node_im [1:2*NP-1];
    logic signed [WT-1:0]   r_v_re;
    logic signed [WT-1:0]   r_v_im;
    quant_tag_t             r_tag [0:LV+2];
    logic                   r_out_valid;
    logic [WIN_LOG2:0]      r_acc;
    logic [WIN_LOG2:0]      r_sat_count;
    logic                   r_sat_valid;

    assign w_acc = enable & in_valid;
    assign w_k0  = w_acc && (r_k == '0);

    // The k=0 sample already uses the config that becomes active with it.
    always_comb begin
        w_cfg_port.gain  = noise_gain;
        w_cfg_port.shift = shift;
        w_cfg_port.mode  = quant_mode_e'(mode);
        w_cfg_smp        = r_active;
        if (w_k0) begin
            if (cfg_load) begin
                w_cfg_smp = w_cfg_port;
            end else if (r_pend) begin
                w_cfg_smp = r_pending;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k        <= '0;
            r_active   <= '0;
            r_pending  <= '0;
            r_pend     <= 1'b0;
            r_noise_re <= '0;
            r_noise_im <= '0;
        end else begin
            r_noise_re <= noise_real;
            r_noise_im <= noise_imag;
            if (!enable) begin
                r_k <= '0;
                if (cfg_load) begin
                    r_active <= w_cfg_port;
                    r_pend   <= 1'b0;
                end
            end else begin
                if (w_acc) begin
                    r_k <= r_k + 1'b1;
                end
                if (w_k0) begin
                    r_active <= w_cfg_smp;
                    r_pend   <= 1'b0;
                end else if (cfg_load) begin
                    r_pending <= w_cfg_port;
                    r_pend    <= 1'b1;
                end
            end
        end
    end

    // Heap-ordered tree: leaves at NP..2NP-1, root at node 1, one register per node.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 1; n < 2 * NP; n++) begin
                r_node_re[n] <= '0;
                r_node_im[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NCH; n++) begin
                r_node_re[NP+n] <= WT'($signed(ch_real[n]));
                r_node_im[NP+n] <= WT'($signed(ch_imag[n]));
            end
            for (int n = NCH; n < NP; n++) begin
                r_node_re[NP+n] <= '0;
                r_node_im[NP+n] <= '0;
            end
            for (int n = 1; n < NP; n++) begin
                r_node_re[n] <= r_node_re[2*n] + r_node_re[2*n+1];
                r_node_im[n] <= r_node_im[2*n] + r_node_im[2*n+1];
            end
        end
    end

    assign w_gain_s     = {1'b0, r_tag[0].cfg.gain};
    assign w_nz_prod_re = 17'((33'(r_noise_re) * 33'(w_gain_s)) >>> 16);
    assign w_nz_prod_im = 17'((33'(r_noise_im) * 33'(w_gain_s)) >>> 16);

    if (LV == 0) begin : g_nz_direct
        assign w_nz_re = w_nz_prod_re;
        assign w_nz_im = w_nz_prod_im;
    end else begin : g_nz_pipe
        logic signed [16:0] r_nzd_re [1:LV];
        logic signed [16:0] r_nzd_im [1:LV];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 1; j <= LV; j++) begin
                    r_nzd_re[j] <= '0;
                    r_nzd_im[j] <= '0;
                end
            end else begin
                r_nzd_re[1] <= w_nz_prod_re;
                r_nzd_im[1] <= w_nz_prod_im;
                for (int j = 2; j <= LV; j++) begin
                    r_nzd_re[j] <= r_nzd_re[j-1];
                    r_nzd_im[j] <= r_nzd_im[j-1];
                end
            end
        end
        assign w_nz_re = r_nzd_re[LV];
        assign w_nz_im = r_nzd_im[LV];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v_re <= '0;
            r_v_im <= '0;
            for (int j = 0; j <= LV + 2; j++) begin
                r_tag[j] <= '0;
            end
        end else begin
            r_v_re         <= r_node_re[1] + WT'(w_nz_re);
            r_v_im         <= r_node_im[1] + WT'(w_nz_im);
            r_tag[0].valid <= w_acc;
            r_tag[0].last  <= w_acc & (&r_k);
            r_tag[0].cfg   <= w_cfg_smp;
            for (int j = 1; j <= LV + 2; j++) begin
                r_tag[j] <= r_tag[j-1];
                if (!enable) begin
                    r_tag[j].valid <= 1'b0;
                end
            end
        end
    end

    assign w_ld = r_tag[LV+2].valid & enable;

    gps_bb_quantizer_slice #(
        .WT    (WT),
        .W_OUT (W_OUT)
    ) u_slice_re (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_v     (r_v_re),
        .i_shift (r_tag[LV+1].cfg.shift),
        .i_mode  (r_tag[LV+1].cfg.mode),
        .i_ld    (w_ld),
        .o_q     (real_out),
        .o_clip  (w_clip_re)
    );

    gps_bb_quantizer_slice #(
        .WT    (WT),
        .W_OUT (W_OUT)
    ) u_slice_im (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_v     (r_v_im),
        .i_shift (r_tag[LV+1].cfg.shift),
        .i_mode  (r_tag[LV+1].cfg.mode),
        .i_ld    (w_ld),
        .o_q     (imag_out),
        .o_clip  (w_clip_im)
    );

    assign w_cnt = r_acc + (WIN_LOG2+1)'(w_clip_re | w_clip_im);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_sat_count <= '0;
            r_sat_valid <= 1'b0;
        end else begin
            r_out_valid <= w_ld;
            r_sat_valid <= 1'b0;
            if (!enable) begin
                r_acc <= '0;
            end else if (w_ld) begin
                if (r_tag[LV+2].last) begin
                    r_sat_count <= w_cnt;
                    r_sat_valid <= 1'b1;
                    r_acc       <= '0;
                end else begin
                    r_acc <= w_cnt;
                end
            end
        end
    end

    assign cfg_pending     = r_pend;
    assign out_valid       = r_out_valid;
    assign sat_count       = r_sat_count;
    assign sat_count_valid = r_sat_valid;

endmodule

// File: tb/tb_gps_bb_quantizer.sv
// Scoreboard bench for gps_bb_quantizer: directed vectors with hand-computed outputs.
module tb_gps_bb_quantizer;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             in_valid;
    logic [3:0][15:0] ch_real;
    logic [3:0][15:0] ch_imag;
    logic [15:0]      noise_real;
    logic [15:0]      noise_imag;
    logic [15:0]      noise_gain;
    logic [4:0]       shift;
    logic             mode;
    logic             cfg_load;
    logic             cfg_pending;
    logic             out_valid;
    logic [2:0]       real_out;
    logic [2:0]       imag_out;
    logic [4:0]       sat_count;
    logic             sat_count_valid;

    gps_bb_quantizer #(
        .NCH      (4),
        .W_IN     (16),
        .W_OUT    (3),
        .WIN_LOG2 (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .in_valid        (in_valid),
        .ch_real         (ch_real),
        .ch_imag         (ch_imag),
        .noise_real      (noise_real),
        .noise_imag      (noise_imag),
        .noise_gain      (noise_gain),
        .shift           (shift),
        .mode            (mode),
        .cfg_load        (cfg_load),
        .cfg_pending     (cfg_pending),
        .out_valid       (out_valid),
        .real_out        (real_out),
        .imag_out        (imag_out),
        .sat_count       (sat_count),
        .sat_count_valid (sat_count_valid)
    );

    typedef struct {
        int re;
        int im;
        int cyc;
    } exp_t;

    exp_t eq[$];
    int   sq[$];
    exp_t e_mon;
    int   s_mon;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   k_m   = 0;
    int   acc_m = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (eq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out: out_valid=1 expected 0 at cycle %0d", cyc);
                end else begin
                    e_mon = eq.pop_front();
                    chk("real_out", int'(real_out), e_mon.re);
                    chk("imag_out", int'(imag_out), e_mon.im);
                    chk("latency", cyc - e_mon.cyc, 6);
                end
            end
            if (sat_count_valid) begin
                if (sq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_sat: sat_count_valid=1 expected 0 at cycle %0d", cyc);
                end else begin
                    s_mon = sq.pop_front();
                    chk("sat_count", int'(sat_count), s_mon);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Channel sum spread over all four inputs so every tree leaf is exercised.
    task automatic send(input int sr, input int si, input int nr, input int ni,
                        input int er, input int ei, input int clip);
        ch_real[0] = 16'(sr - 3 * (sr / 4));
        ch_imag[0] = 16'(si - 3 * (si / 4));
        for (int i = 1; i < 4; i++) begin
            ch_real[i] = 16'(sr / 4);
            ch_imag[i] = 16'(si / 4);
        end
        noise_real = 16'(nr);
        noise_imag = 16'(ni);
        in_valid   = 1'b1;
        eq.push_back('{re: er, im: ei, cyc: cyc});
        acc_m += clip;
        if (k_m == 15) begin
            sq.push_back(acc_m);
            acc_m = 0;
        end
        k_m = (k_m + 1) % 16;
        tick();
        in_valid = 1'b0;
        cfg_load = 1'b0;
    endtask

    task automatic cfg(input int g, input int s, input int m);
        enable     = 1'b0;
        k_m        = 0;
        acc_m      = 0;
        noise_gain = 16'(g);
        shift      = 5'(s);
        mode       = 1'(m);
        cfg_load   = 1'b1;
        tick();
        cfg_load = 1'b0;
        tick();
        enable = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        in_valid   = 1'b0;
        ch_real    = '0;
        ch_imag    = '0;
        noise_real = '0;
        noise_imag = '0;
        noise_gain = '0;
        shift      = '0;
        mode       = 1'b0;
        cfg_load   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_real_out", int'(real_out), 0);
        chk("rst_imag_out", int'(imag_out), 0);
        chk("rst_sat_count", int'(sat_count), 0);
        chk("rst_sat_valid", int'(sat_count_valid), 0);
        chk("rst_cfg_pending", int'(cfg_pending), 0);
        tick();
        enable = 1'b1;
        tick();

        // Default config: mode 0, shift 0, gain 0.
        send(4, 0, 0, 0, 3'b011, 3'b000, 1);
        send(-2, 3, 0, 0, 3'b110, 3'b011, 0);
        send(-4, -5, 0, 0, 3'b100, 3'b100, 1);
        idle(10);

        // Mode 0, shift 1: round half toward +inf.
        cfg(0, 1, 0);
        send(5, -5, 0, 0, 3'b011, 3'b110, 0);
        send(2, -1, 0, 0, 3'b001, 3'b000, 0);
        send(7, -9, 0, 0, 3'b011, 3'b100, 1);
        send(-10, 0, 0, 0, 3'b100, 3'b000, 1);
        idle(10);

        // Mode 1 (sign-magnitude), shift 0.
        cfg(0, 0, 1);
        send(-1, 9, 0, 0, 3'b100, 3'b011, 1);
        send(2, -4, 0, 0, 3'b010, 3'b111, 0);
        send(-5, 0, 0, 0, 3'b111, 3'b000, 1);
        idle(10);

        // Noise path: 0x0800 * 0x8000 >> 16 = 1024, shift 8.
        cfg(32'h8000, 8, 0);
        send(0, 0, 16'h0800, -2048, 3'b011, 3'b100, 1);
        send(128, 0, 16'h0100, 0, 3'b001, 3'b000, 0);
        idle(10);
        cfg(0, 8, 0);
        send(0, 0, 16'h0800, -2048, 3'b000, 3'b000, 0);
        idle(10);

        // Windowed clip counting and window-aligned config switch.
        cfg(0, 0, 0);
        for (int i = 0; i < 16; i++) send(100, 0, 0, 0, 3'b011, 3'b000, 1);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                shift    = 5'd7;
                cfg_load = 1'b1;
            end
            send(100, 0, 0, 0, 3'b011, 3'b000, 1);
            if (i == 5) chk("pending_set", int'(cfg_pending), 1);
        end
        chk("pending_hold", int'(cfg_pending), 1);
        send(100, 0, 0, 0, 3'b001, 3'b000, 0);
        chk("pending_clear", int'(cfg_pending), 0);
        for (int i = 1; i < 16; i++) send(100, 0, 0, 0, 3'b001, 3'b000, 0);

        // Enable dropped at k=9: in-flight samples and partial window discarded.
        for (int i = 0; i < 10; i++) send(100, 0, 0, 0, 3'b001, 3'b000, 0);
        enable = 1'b0;
        tick();
        eq.delete();
        sq.delete();
        k_m   = 0;
        acc_m = 0;
        idle(10);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_sat_valid", int'(sat_count_valid), 0);
        chk("flush_sat_hold", int'(sat_count), 0);
        enable = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) send(500, 0, 0, 0, 3'b011, 3'b000, 1);
            else send(100, 0, 0, 0, 3'b001, 3'b000, 0);
        end
        idle(10);

        // Reset at k=9 clears everything, including the active config.
        for (int i = 0; i < 10; i++) send(100, 0, 0, 0, 3'b001, 3'b000, 0);
        rst = 1'b1;
        eq.delete();
        sq.delete();
        k_m   = 0;
        acc_m = 0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_real_out", int'(real_out), 0);
        chk("mid_rst_sat_count", int'(sat_count), 0);
        chk("mid_rst_cfg_pending", int'(cfg_pending), 0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i < 3) send(100, 0, 0, 0, 3'b011, 3'b000, 1);
            else if (i == 8) send(-3, 2, 0, 0, 3'b101, 3'b010, 0);
            else send(2, 0, 0, 0, 3'b010, 3'b000, 0);
        end
        idle(12);

        chk("out_queue_drained", eq.size(), 0);
        chk("sat_queue_drained", sq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
